// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the datapath load/store port.
// It accepts one request, waits LATENCY cycles, commits the access to an
// internal word array and then presents ReadData or a store acknowledge
// until the requester takes it.
// Optional build macro: DMEM_BYTE_EN_EN.
//   Defined   - req_be selects which bytes a store writes.
//   Undefined - req_be is ignored and every non-error store writes all 32 bits.

module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT_LOAD    = 4'(LATENCY - 1);
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        accept;
    logic        commit;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be_raw;
    logic [3:0]  c_be;
    logic        c_err;
    logic [IDX_W-1:0] c_idx;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic        err_q;

    // State and latency counter register; reset parks the FSM in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and handshake outputs; commit fires on the edge entering RESP
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        commit    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        commit  = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = RESP;
                    end else begin
                        cnt_d   = LAT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Commit operands: with a single-cycle latency the commit happens on the
    // accept edge itself, so the live request is used instead of the latch
    always_comb begin
        c_we     = lat_we;
        c_addr   = lat_addr;
        c_wdata  = lat_wdata;
        c_be_raw = lat_be;
        if (state_q == IDLE) begin
            c_we     = req_we;
            c_addr   = req_addr;
            c_wdata  = req_wdata;
            c_be_raw = req_be;
        end
        c_err = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= DEPTH_LIMIT);
        c_idx = c_addr[IDX_W+1:2];
`ifdef DMEM_BYTE_EN_EN
        c_be  = c_be_raw;
`else
        c_be  = c_be_raw | 4'hF;
`endif
    end

    // Request latch and response registers; the response is held until the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            if (commit) begin
                err_q   <= c_err;
                rdata_q <= (c_err || c_we) ? 32'd0 : mem[c_idx];
            end
        end
    end

    // Word array store; contents survive reset, only enabled bytes of a legal store change
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized self-checking bench for data_mem_responder.
// A word-array reference model predicts every response; a second instance
// with LATENCY=1 covers single-cycle latency and back-to-back throughput.
`timescale 1ns/1ps

module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 64;
`ifdef DMEM_BYTE_EN_EN
    localparam bit BE_HONOURED = 1'b1;
`else
    localparam bit BE_HONOURED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        req_valid1;
    logic        req_ready1;
    logic        req_we1;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata1;
    logic [3:0]  req_be1;
    logic        rsp_valid1;
    logic        rsp_ready1;
    logic [31:0] rsp_rdata1;
    logic        rsp_err1;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] model [DEPTH];

    // Free-running clock
    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid1),
        .req_ready (req_ready1),
        .req_we    (req_we1),
        .req_addr  (req_addr1),
        .req_wdata (req_wdata1),
        .req_be    (req_be1),
        .rsp_valid (rsp_valid1),
        .rsp_ready (rsp_ready1),
        .rsp_rdata (rsp_rdata1),
        .rsp_err   (rsp_err1)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference model: one access against a plain word array
    function automatic void modelAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] be, output logic [31:0] rdata, output logic err);
        int unsigned word;
        word  = addr / 4;
        err   = (addr % 4 != 0) || (word >= DEPTH);
        rdata = 32'd0;
        if (err) return;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b] || !BE_HONOURED) model[word][8*b +: 8] = wdata[8*b +: 8];
            end
        end else begin
            rdata = model[word];
        end
    endfunction

    // One full transaction on the main instance, checked against the model
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input int holdCycles, input bit noise,
                                 output logic [31:0] gotRdata);
        logic [31:0] expR;
        logic        expE;
        int          n;
        gotRdata = 32'd0;
        modelAccess(we, addr, wdata, be, expR, expE);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (noise) begin
            req_we    = 1'b1;
            req_addr  = 32'($urandom_range(0, DEPTH - 1) * 4);
            req_wdata = $urandom;
            req_be    = 4'hF;
        end else begin
            req_valid = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!rsp_valid) checkOutput("req_ready_wait", {31'd0, req_ready}, 32'd0);
        end while (!rsp_valid && n < 40);
        checkOutput("latency", 32'(n), 32'(LAT));
        checkOutput("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        if (!rsp_valid) begin
            req_valid = 1'b0;
            return;
        end
        checkOutput("rsp_rdata", rsp_rdata, expR);
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, expE});
        checkOutput("req_ready_resp", {31'd0, req_ready}, 32'd0);
        gotRdata = rsp_rdata;
        for (int d = 0; d < holdCycles; d++) begin
            @(negedge clk);
            checkOutput("hold_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("hold_rdata", rsp_rdata, expR);
            checkOutput("hold_err", {31'd0, rsp_err}, {31'd0, expE});
            checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    // Abort watchdog so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed test plan, randomized traffic, LATENCY=1 instance
    initial begin
        logic [31:0] r;
        logic [31:0] saved;
        logic [31:0] addr;
        logic        readyLog [20];
        logic        validLog [20];
        int          accepts;
        int          sel;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_be     = 4'd0;
        rsp_ready  = 1'b0;
        req_valid1 = 1'b0;
        req_we1    = 1'b0;
        req_addr1  = 32'd0;
        req_wdata1 = 32'd0;
        req_be1    = 4'd0;
        rsp_ready1 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;

        for (int w = 0; w < DEPTH; w++) applyStimulus(1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0, r);

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, r);
        applyStimulus(1'b0, 32'h10, 32'd0, 4'hF, 0, 1'b0, r);
        checkOutput("load_0x10", r, 32'hDEADBEEF);

        applyStimulus(1'b0, 32'h13, 32'd0, 4'hF, 0, 1'b0, r);
        saved = model[0];
        applyStimulus(1'b1, 32'h100, 32'h12345678, 4'hF, 0, 1'b0, r);
        applyStimulus(1'b0, 32'h0, 32'd0, 4'hF, 0, 1'b0, r);
        checkOutput("load_0x0_after_oob", r, saved);

        applyStimulus(1'b0, 32'h10, 32'd0, 4'hF, 5, 1'b0, r);

        applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, r);
        applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0, r);
        applyStimulus(1'b0, 32'h20, 32'd0, 4'hF, 0, 1'b0, r);
`ifdef DMEM_BYTE_EN_EN
        checkOutput("byte_enable_merge", r, 32'h11BB33DD);
`else
        checkOutput("byte_enable_ignored", r, 32'hAABBCCDD);
`endif
        applyStimulus(1'b1, 32'h24, 32'h0BADF00D, 4'b0000, 0, 1'b0, r);
        applyStimulus(1'b0, 32'h24, 32'd0, 4'hF, 0, 1'b0, r);

        applyStimulus(1'b1, 32'h8, 32'h0, 4'hF, 0, 1'b0, r);
        applyStimulus(1'b0, 32'h10, 32'd0, 4'hF, 0, 1'b0, r);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h8;
        req_wdata = 32'h55;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_wait_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_wait_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_wait_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h8, 32'd0, 4'hF, 0, 1'b0, r);
        checkOutput("load_0x8_after_rst", r, 32'h0);

        for (int t = 0; t < 150; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 6)      addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel == 7) addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 8) addr = 32'((DEPTH + $urandom_range(0, 200)) * 4);
            else               addr = $urandom;
            applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r);
        end

        @(negedge clk);
        req_valid1 = 1'b1;
        req_we1    = 1'b1;
        req_addr1  = 32'h4;
        req_wdata1 = 32'hCAFEF00D;
        req_be1    = 4'hF;
        rsp_ready1 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            readyLog[c] = req_ready1;
            validLog[c] = rsp_valid1;
            @(negedge clk);
        end
        accepts = 0;
        for (int c = 0; c < 20; c++) begin
            if (readyLog[c]) begin
                accepts++;
                if (c < 19) checkOutput("lat1_rsp_next_cycle", {31'd0, validLog[c+1]}, 32'd1);
            end
        end
        checkOutput("lat1_accepts_in_20", 32'(accepts), 32'd10);
        req_valid1 = 1'b0;
        repeat (2) @(negedge clk);
        req_we1    = 1'b0;
        req_valid1 = 1'b1;
        @(posedge clk);
        #1;
        req_valid1 = 1'b0;
        @(negedge clk);
        checkOutput("lat1_load_valid", {31'd0, rsp_valid1}, 32'd1);
        checkOutput("lat1_load_rdata", rsp_rdata1, 32'hCAFEF00D);
        checkOutput("lat1_load_err", {31'd0, rsp_err1}, 32'd0);
        @(negedge clk);
        checkOutput("lat1_post_hs_valid", {31'd0, rsp_valid1}, 32'd0);
        checkOutput("lat1_post_hs_ready", {31'd0, req_ready1}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the datapath's load/store port: accepts one request, waits a fixed latency, then returns ReadData or a write acknowledge.
- Produces the ReadData consumed by the writeback result mux; takes ALUResult as the address and WriteData as the store data.
- Replaces the zero-latency data memory so multi-cycle memory timing can be modelled behind a valid/ready handshake.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the internal array; legal word index 0..DEPTH_WORDS-1.
- LATENCY, 2, cycles from request accept to rsp_valid assertion; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address, driven from ALUResult.
- req_wdata  input  32  store data, driven from WriteData.
- req_be  input  4  byte enables; bit i enables byte i, which is bits 8i+7:8i.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data, feeding ReadData.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- While rst is high: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0. Array contents are not reset.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch we, addr, wdata and be.
  - If LATENCY = 1, go to RESP. Otherwise load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready = 0.
  - Decrement the counter each cycle.
  - When counter = 1, commit and go to RESP. rsp_valid therefore rises exactly LATENCY cycles after the accept edge.
- Commit, performed on the edge entering RESP:
  - err = (addr[1:0] != 0) || (addr[31:2] >= DEPTH_WORDS).
  - If err = 1: no array write; rsp_rdata = 0; rsp_err = 1.
  - Else if store: write the enabled bytes of wdata to word addr[31:2]; rsp_rdata = 0; rsp_err = 0.
  - Else (load): rsp_rdata = word addr[31:2]; rsp_err = 0.
- RESP:
  - rsp_valid = 1, with rsp_rdata and rsp_err held stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE. rsp_valid = 0 and req_ready = 1 from the next cycle.
- No request is accepted in the same cycle as a response handshake. Maximum throughput is one transaction per LATENCY+1 cycles.
- req_valid while not in IDLE is ignored; the requester must hold its request until req_ready.
- Reset asserted in WAIT: the transaction is dropped and nothing is written. Reset asserted in RESP: the already committed write persists and the response is lost.
- A load of a word written earlier returns the post-write value; no read-before-write hazard exists because each transaction completes before the next is accepted.

Optional Feature:
- Macro DMEM_BYTE_EN_EN.
- Defined: req_be is honoured as specified above; a store with req_be = 4'b0000 writes nothing but still responds with rsp_err = 0.
- Undefined: req_be is ignored and every non-error store writes all 32 bits.

Test Plan:
- LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF accepted at cycle 0 -> rsp_valid at cycle 2, rsp_err = 0. Then load 0x10 -> rsp_rdata = 0xDEADBEEF.
- Misaligned load addr 0x13 -> rsp_err = 1, rsp_rdata = 0. Out-of-range store addr 0x100 (word 64) -> rsp_err = 1; a subsequent load of 0x0 is unchanged.
- Back-pressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay constant and req_ready stays 0. Raise rsp_ready -> req_ready = 1 on the next cycle.
- Byte enables (macro defined): word 0x20 = 0x11223344, store wdata 0xAABBCCDD with be 4'b0101 -> load returns 0x11BB33DD. Macro undefined -> load returns 0xAABBCCDD.
- Reset in WAIT during a store of 0x55 to 0x8 (previous value 0x0) -> outputs return to reset values, req_ready = 1, and a load of 0x8 returns 0x0.
- LATENCY=1: accept at cycle 0 -> rsp_valid at cycle 1. Keep rsp_ready = 1 with back-to-back requests -> one accept every 2 cycles.
